// File: rtl/clut_fill_ctrl_pkg.sv
// Shared GPU definitions for the CLUT cache miss/fill sequencer.
package clut_fill_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DRAIN} fill_state_e;

  localparam int CLUT_BEATS = 8;
  localparam int VRAM_AW    = 18;

endpackage

// File: rtl/clut_fill_ctrl.sv
// CLUT cache miss sequencer: picks a missing requester, reads its 16-colour
// block from VRAM as one 8-word burst and streams it into the cache.
module clut_fill_ctrl
  import clut_fill_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               i_nrst,
  input  logic [14:0]        i_clutId,
  input  logic               i_miss1,
  input  logic               i_miss2,
  input  logic [7:0]         i_readIdx1,
  input  logic [7:0]         i_readIdx2,
  output logic               o_memReq,
  output logic [VRAM_AW-1:0] o_memAdr,
  input  logic               i_memAck,
  input  logic               i_memValid,
  input  logic [31:0]        i_memData,
  output logic               o_write,
  output logic [2:0]         o_writeIdxInBlk,
  output logic [31:0]        o_colorIn,
  output logic               o_busy,
  output logic               o_fillSel,
  output logic               o_fillDone
);

  localparam logic [2:0] LAST_BEAT = 3'(CLUT_BEATS - 1);

  fill_state_e        state_q, state_d;
  logic [14:0]        clut_q, clut_d;
  logic               fillSel_q, fillSel_d;
  logic               memReq_q, memReq_d;
  logic [VRAM_AW-1:0] memAdr_q, memAdr_d;
  logic [2:0]         beat_q, beat_d;
  logic               write_q, write_d;
  logic [2:0]         wIdx_q, wIdx_d;
  logic [31:0]        color_q, color_d;
  logic               done_q, done_d;

  logic [3:0]         sel_blk;
  logic [8:0]         xword;
  logic               clut_changed;
  logic               unused_idx_bits;

  // Only the block number of a palette index matters for the fill.
  assign unused_idx_bits = ^{i_readIdx1[3:0], i_readIdx2[3:0]};

  // Block offset wraps inside the 512-word VRAM line, never into Y.
  assign sel_blk      = i_miss1 ? i_readIdx1[7:4] : i_readIdx2[7:4];
  assign xword        = {i_clutId[5:0], 3'b000} + {2'b00, sel_blk, 3'b000};
  assign clut_changed = (i_clutId != clut_q);

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= IDLE;
      clut_q    <= '0;
      fillSel_q <= 1'b0;
      memReq_q  <= 1'b0;
      memAdr_q  <= '0;
      beat_q    <= '0;
      write_q   <= 1'b0;
      wIdx_q    <= '0;
      color_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clut_q    <= clut_d;
      fillSel_q <= fillSel_d;
      memReq_q  <= memReq_d;
      memAdr_q  <= memAdr_d;
      beat_q    <= beat_d;
      write_q   <= write_d;
      wIdx_q    <= wIdx_d;
      color_q   <= color_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clut_d    = clut_q;
    fillSel_d = fillSel_q;
    memReq_d  = memReq_q;
    memAdr_d  = memAdr_q;
    beat_d    = beat_q;
    write_d   = 1'b0;
    wIdx_d    = wIdx_q;
    color_d   = color_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // The cycle carrying the final write is still busy; misses wait one cycle.
        if (!done_q && (i_miss1 || i_miss2)) begin
          fillSel_d = !i_miss1;
          clut_d    = i_clutId;
          memAdr_d  = {i_clutId[14:6], xword};
          memReq_d  = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (i_memAck) begin
          memReq_d = 1'b0;
          beat_d   = '0;
          state_d  = clut_changed ? DRAIN : FILL;
        end
      end
      FILL: begin
        if (clut_changed) begin
          state_d = DRAIN;
          if (i_memValid) begin
            beat_d = beat_q + 3'd1;
            if (beat_q == LAST_BEAT) state_d = IDLE;
          end
        end else if (i_memValid) begin
          write_d = 1'b1;
          wIdx_d  = beat_q;
          color_d = i_memData;
          beat_d  = beat_q + 3'd1;
          if (beat_q == LAST_BEAT) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (i_memValid) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == LAST_BEAT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_memReq        = memReq_q;
  assign o_memAdr        = memAdr_q;
  assign o_write         = write_q;
  assign o_writeIdxInBlk = wIdx_q;
  assign o_colorIn       = color_q;
  assign o_fillSel       = fillSel_q;
  assign o_fillDone      = done_q;
  assign o_busy          = (state_q != IDLE) || done_q;

endmodule

// File: tb/tb_clut_fill_ctrl.sv
// Randomised scoreboard bench for clut_fill_ctrl: the driver plays requesters
// and the VRAM arbiter, a monitor pops expected requests/writes and compares.
module tb_clut_fill_ctrl;

  logic        clk;
  logic        i_nrst;
  logic [14:0] i_clutId;
  logic        i_miss1, i_miss2;
  logic [7:0]  i_readIdx1, i_readIdx2;
  logic        o_memReq;
  logic [17:0] o_memAdr;
  logic        i_memAck, i_memValid;
  logic [31:0] i_memData;
  logic        o_write;
  logic [2:0]  o_writeIdxInBlk;
  logic [31:0] o_colorIn;
  logic        o_busy, o_fillSel, o_fillDone;

  clut_fill_ctrl dut (
    .clk(clk), .i_nrst(i_nrst), .i_clutId(i_clutId),
    .i_miss1(i_miss1), .i_miss2(i_miss2),
    .i_readIdx1(i_readIdx1), .i_readIdx2(i_readIdx2),
    .o_memReq(o_memReq), .o_memAdr(o_memAdr), .i_memAck(i_memAck),
    .i_memValid(i_memValid), .i_memData(i_memData),
    .o_write(o_write), .o_writeIdxInBlk(o_writeIdxInBlk), .o_colorIn(o_colorIn),
    .o_busy(o_busy), .o_fillSel(o_fillSel), .o_fillDone(o_fillDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [17:0] adr; logic sel;} req_t;
  typedef struct packed {logic [2:0] idx; logic [31:0] data; logic done; logic sel;} wr_t;

  req_t exp_req_q[$];
  wr_t  exp_wr_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference address: Y selects the VRAM line, X and block add in word units mod 512.
  function automatic logic [17:0] ref_addr(input logic [14:0] clut, input logic [7:0] idx);
    int x, y, blk, xw;
    x   = int'(clut) % 64;
    y   = int'(clut) / 64;
    blk = int'(idx) / 16;
    xw  = (x * 8 + blk * 8) % 512;
    return 18'(y * 512 + xw);
  endfunction

  task automatic push_req(input logic sel);
    req_t r;
    r.adr = ref_addr(i_clutId, sel ? i_readIdx2 : i_readIdx1);
    r.sel = sel;
    exp_req_q.push_back(r);
  endtask

  // Monitor / scoreboard
  logic req_prev = 1'b0;
  req_t cur_req  = '0;
  always @(negedge clk) begin
    if (!i_nrst) begin
      req_prev = 1'b0;
    end else begin
      if (o_memReq && !req_prev) begin
        check("req_expected", 64'(exp_req_q.size() != 0), 64'd1);
        if (exp_req_q.size() != 0) begin
          cur_req = exp_req_q.pop_front();
          check("req_adr", 64'(o_memAdr), 64'(cur_req.adr));
          check("req_sel", 64'(o_fillSel), 64'(cur_req.sel));
        end
      end else if (o_memReq) begin
        check("req_adr_stable", 64'(o_memAdr), 64'(cur_req.adr));
      end
      if (o_write) begin
        check("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
        if (exp_wr_q.size() != 0) begin
          wr_t w;
          w = exp_wr_q.pop_front();
          check("wr_idx", 64'(o_writeIdxInBlk), 64'(w.idx));
          check("wr_data", 64'(o_colorIn), 64'(w.data));
          check("wr_done", 64'(o_fillDone), 64'(w.done));
          check("wr_sel", 64'(o_fillSel), 64'(w.sel));
          check("wr_busy", 64'(o_busy), 64'd1);
        end
      end else if (o_fillDone) begin
        check("done_with_write", 64'(o_write), 64'd1);
      end
      req_prev = o_memReq;
    end
  end

  // Raise misses at a negedge; the request must appear one cycle later.
  task automatic issue(input logic m1, input logic m2, input logic [7:0] ix1, input logic [7:0] ix2);
    i_readIdx1 = ix1;
    i_readIdx2 = ix2;
    i_miss1    = m1;
    i_miss2    = m2;
    push_req(!m1);
    @(negedge clk);
    check("req_latency", 64'(o_memReq), 64'd1);
  endtask

  // Acts as the VRAM arbiter for one burst; abort_beat >= 8 means no CLUT change.
  task automatic serve_burst(input logic sel, input int ack_delay, input int max_gap,
                             input int abort_beat, input logic [14:0] new_clut);
    int          waited;
    int          gap;
    logic        aborted;
    logic        pending;
    logic [31:0] d;
    wr_t         w;
    waited  = 0;
    aborted = 1'b0;
    while (!o_memReq && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("req_seen", 64'(o_memReq), 64'd1);
    if (!o_memReq) return;
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      check("req_held", 64'(o_memReq), 64'd1);
    end
    i_memAck = 1'b1;
    @(negedge clk);
    i_memAck = 1'b0;
    check("req_dropped", 64'(o_memReq), 64'd0);
    for (int b = 0; b < 8; b++) begin
      gap = int'($urandom_range(max_gap, 0));
      repeat (gap) @(negedge clk);
      d          = $urandom;
      i_memValid = 1'b1;
      i_memData  = d;
      if (b == abort_beat) begin
        i_clutId = new_clut;
        aborted  = 1'b1;
      end
      if (!aborted) begin
        w.idx  = 3'(b);
        w.data = d;
        w.done = (b == 7);
        w.sel  = sel;
        exp_wr_q.push_back(w);
      end
      @(negedge clk);
      i_memValid = 1'b0;
    end
    if (sel) i_miss2 = 1'b0;
    else     i_miss1 = 1'b0;
    pending = !sel && i_miss2;
    if (pending) push_req(1'b1);
    @(negedge clk);
    check("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
    if (!pending)      check("busy_cleared", 64'(o_busy), 64'd0);
    else if (!aborted) check("no_early_req", 64'(o_memReq), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_memReq"}, 64'(o_memReq), 64'd0);
    check({tag, "_memAdr"}, 64'(o_memAdr), 64'd0);
    check({tag, "_write"}, 64'(o_write), 64'd0);
    check({tag, "_wIdx"}, 64'(o_writeIdxInBlk), 64'd0);
    check({tag, "_color"}, 64'(o_colorIn), 64'd0);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_fillSel"}, 64'(o_fillSel), 64'd0);
    check({tag, "_fillDone"}, 64'(o_fillDone), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ix1, ix2;
    logic [1:0]  pat;
    logic [31:0] d;
    wr_t         w;
    int          ab;
    i_nrst = 1'b0; i_clutId = '0; i_miss1 = 1'b0; i_miss2 = 1'b0;
    i_readIdx1 = '0; i_readIdx2 = '0; i_memAck = 1'b0; i_memValid = 1'b0; i_memData = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    i_nrst = 1'b1;
    @(negedge clk);

    // Basic fill: X=2, Y=5, index 0x37 -> block 3
    i_clutId = {9'd5, 6'd2};
    issue(1'b1, 1'b0, 8'h37, 8'h00);
    check("fill_adr", 64'(o_memAdr), 64'({9'd5, 9'd40}));
    serve_burst(1'b0, 0, 0, 8, '0);

    // Wrap within the VRAM line: X=63, block 15
    i_clutId = {9'd7, 6'd63};
    issue(1'b1, 1'b0, 8'hF0, 8'h00);
    check("wrap_adr", 64'(o_memAdr), 64'({9'd7, 9'd112}));
    serve_burst(1'b0, 2, 1, 8, '0);

    // Priority: both miss together, port 1 first, port 2 at done+2
    i_clutId = 15'(12'h4C5);
    issue(1'b1, 1'b1, 8'h3A, 8'h95);
    serve_burst(1'b0, 1, 2, 8, '0);
    @(negedge clk);
    check("b2b_req", 64'(o_memReq), 64'd1);
    serve_burst(1'b1, 0, 1, 8, '0);

    // Abort: CLUT changes together with beat 3
    i_clutId = {9'd100, 6'd17};
    issue(1'b1, 1'b0, 8'h21, 8'h00);
    serve_burst(1'b0, 1, 1, 3, {9'd101, 6'd17});

    // Stalled handshake and beat gaps
    issue(1'b0, 1'b1, 8'h00, 8'hC4);
    serve_burst(1'b1, 10, 3, 8, '0);

    // Reset in the middle of a fill
    i_clutId = {9'd33, 6'd9};
    issue(1'b1, 1'b0, 8'h52, 8'h00);
    i_memAck = 1'b1;
    @(negedge clk);
    i_memAck = 1'b0;
    for (int b = 0; b < 3; b++) begin
      d = $urandom;
      i_memValid = 1'b1;
      i_memData  = d;
      w.idx = 3'(b); w.data = d; w.done = 1'b0; w.sel = 1'b0;
      exp_wr_q.push_back(w);
      @(negedge clk);
      i_memValid = 1'b0;
    end
    #2 i_nrst = 1'b0;
    #1 check_all_zero("midreset");
    i_miss1 = 1'b0;
    check("midreset_wr_queue", 64'(exp_wr_q.size()), 64'd0);
    exp_wr_q.delete();
    @(negedge clk);
    i_nrst = 1'b1;
    @(negedge clk);
    issue(1'b1, 1'b0, 8'h52, 8'h00);
    serve_burst(1'b0, 0, 0, 8, '0);

    // Randomised traffic
    for (int t = 0; t < 16; t++) begin
      i_clutId = 15'($urandom);
      ix1 = 8'($urandom);
      ix2 = 8'($urandom);
      pat = 2'($urandom_range(3, 1));
      ab  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : 8;
      issue(pat[0], pat[1], ix1, ix2);
      serve_burst(!pat[0], int'($urandom_range(4, 0)), 3, ab,
                  i_clutId ^ 15'(1 << $urandom_range(14, 0)));
      if (pat == 2'b11)
        serve_burst(1'b1, int'($urandom_range(4, 0)), 3, 8, '0);
      repeat (int'($urandom_range(2, 0))) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("final_req_queue", 64'(exp_req_q.size()), 64'd0);
    check("final_wr_queue", 64'(exp_wr_q.size()), 64'd0);
    check("final_busy", 64'(o_busy), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
